// File: rtl/mux_scan_nto1_if.sv
// Channel-mux bus: select/scan controls and packed channel words in, registered word out.
interface mux_scan_nto1_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      hold;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;

  modport master (output mode, sel, hold, din, input dout, ch, valid, wrap);
  modport slave  (input mode, sel, hold, din, output dout, ch, valid, wrap);
endinterface

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 word mux: manual select, or round-robin scan with a per-channel dwell.
module mux_scan_nto1 #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 125
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_nto1_if.slave bus
);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dout_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;
  logic             wrap_q;

  logic [WIDTH-1:0] sel_word, ch_word;
  logic             sel_ok, ch_ok;

  // Index decode by comparison so out-of-range indices never slice past din.
  always_comb begin
    sel_word = '0;
    ch_word  = '0;
    sel_ok   = 1'b0;
    ch_ok    = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_ok   = 1'b1;
        sel_word = bus.din[k*WIDTH +: WIDTH];
      end
      if (ch_q == SEL_W'(k)) begin
        ch_ok   = 1'b1;
        ch_word = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt     <= '0;
    end else if (!bus.mode) begin
      ch_q    <= bus.sel;
      dout_q  <= sel_ok ? sel_word : '0;
      valid_q <= sel_ok;
      cnt     <= '0;
      wrap_q  <= 1'b0;
    end else if (!ch_ok) begin
      // Scan entered on an out-of-range manual index: restart at channel 0.
      ch_q    <= '0;
      cnt     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      dout_q  <= ch_word;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
      if (!bus.hold) begin
        if (cnt != CNT_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          if (ch_q != CH_LAST) begin
            ch_q <= ch_q + 1'b1;
          end else begin
            ch_q   <= '0;
            wrap_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: 8-channel and 5-channel instances, DWELL=4.
module tb_mux_scan_nto1;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] din8;
  logic [4:0] din5;

  mux_scan_nto1_if #(.WIDTH(1), .CHANNELS(8), .SEL_W(3)) bus8 ();
  mux_scan_nto1_if #(.WIDTH(1), .CHANNELS(5), .SEL_W(3)) bus5 ();

  mux_scan_nto1 #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  mux_scan_nto1 #(.WIDTH(1), .CHANNELS(5), .SEL_W(3), .DWELL(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus8.din = din8;
  assign bus5.din = din5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.mode = 1'b1; bus8.sel = 3'd5; bus8.hold = 1'b0;
    bus5.mode = 1'b0; bus5.sel = 3'd3; bus5.hold = 1'b0;
    din8 = 8'hFF; din5 = 5'h1F;
    tick();
    tick();
    n_tests++;
    if (bus8.dout !== 1'b0 || bus8.ch !== 3'd0 || bus8.valid !== 1'b0 || bus8.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: dout=%b ch=%0d valid=%b wrap=%b, want 0/0/0/0",
               bus8.dout, bus8.ch, bus8.valid, bus8.wrap);
    end
    n_tests++;
    if (bus5.dout !== 1'b0 || bus5.ch !== 3'd0 || bus5.valid !== 1'b0 || bus5.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset5: dout=%b ch=%0d valid=%b wrap=%b, want 0/0/0/0",
               bus5.dout, bus5.ch, bus5.valid, bus5.wrap);
    end
    rst = 1'b0;
  endtask

  task automatic test_manual_sweep();
    logic exp_d;
    din8 = 8'b1010_1010;
    bus8.mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      bus8.sel = 3'(s);
      tick();
      exp_d = din8[s];
      n_tests++;
      if (bus8.dout !== exp_d || bus8.ch !== 3'(s) || bus8.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL manual sel=%0d: dout=%b ch=%0d valid=%b, want %b/%0d/1",
                 s, bus8.dout, bus8.ch, bus8.valid, exp_d, s);
      end
    end
    din8 = 8'h55;
    tick();
    n_tests++;
    if (bus8.dout !== 1'b0 || bus8.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL manual din flip: dout=%b wrap=%b, want 0/0", bus8.dout, bus8.wrap);
    end
  endtask

  task automatic test_scan();
    int   exp_ch;
    logic exp_w, exp_d;
    din8 = 8'b1010_1010;
    bus8.mode = 1'b1; bus8.hold = 1'b0;
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      tick();
      exp_ch = (k / 4) % 8;
      exp_w  = (k % 32 == 0);
      exp_d  = din8[((k - 1) / 4) % 8];
      n_tests++;
      if (bus8.ch !== 3'(exp_ch) || bus8.wrap !== exp_w || bus8.dout !== exp_d || bus8.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL scan k=%0d: ch=%0d wrap=%b dout=%b valid=%b, want %0d/%b/%b/1",
                 k, bus8.ch, bus8.wrap, bus8.dout, bus8.valid, exp_ch, exp_w, exp_d);
      end
    end
  endtask

  task automatic test_hold();
    din8 = 8'b1010_1010;
    bus8.mode = 1'b1; bus8.hold = 1'b0;
    do_reset();
    for (int k = 1; k <= 14; k++) tick();
    bus8.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_tests++;
      if (bus8.ch !== 3'd3 || bus8.wrap !== 1'b0 || bus8.dout !== 1'b1) begin
        n_fail++;
        $display("FAIL hold cyc=%0d: ch=%0d wrap=%b dout=%b, want 3/0/1",
                 k, bus8.ch, bus8.wrap, bus8.dout);
      end
    end
    bus8.hold = 1'b0;
    tick();
    n_tests++;
    if (bus8.ch !== 3'd3) begin
      n_fail++;
      $display("FAIL hold release+1: ch=%0d, want 3", bus8.ch);
    end
    tick();
    n_tests++;
    if (bus8.ch !== 3'd4) begin
      n_fail++;
      $display("FAIL hold release+2: ch=%0d, want 4", bus8.ch);
    end
  endtask

  task automatic test_mode_switch();
    din8 = 8'b1010_1010;
    bus8.hold = 1'b0;
    bus8.mode = 1'b0; bus8.sel = 3'd5;
    do_reset();
    tick();
    n_tests++;
    if (bus8.ch !== 3'd5 || bus8.dout !== 1'b1 || bus8.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL switch manual5: ch=%0d dout=%b valid=%b, want 5/1/1",
               bus8.ch, bus8.dout, bus8.valid);
    end
    bus8.mode = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++;
      if (bus8.ch !== ((k < 4) ? 3'd5 : 3'd6) || bus8.dout !== 1'b1) begin
        n_fail++;
        $display("FAIL switch scan k=%0d: ch=%0d dout=%b, want %0d/1",
                 k, bus8.ch, bus8.dout, (k < 4) ? 5 : 6);
      end
    end
    bus8.mode = 1'b0; bus8.sel = 3'd2;
    tick();
    n_tests++;
    if (bus8.ch !== 3'd2 || bus8.dout !== 1'b0 || bus8.valid !== 1'b1 || bus8.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL switch back: ch=%0d dout=%b valid=%b wrap=%b, want 2/0/1/0",
               bus8.ch, bus8.dout, bus8.valid, bus8.wrap);
    end
  endtask

  task automatic test_reset_mid_scan();
    din8 = 8'b1010_1010;
    bus8.mode = 1'b1; bus8.hold = 1'b0;
    do_reset();
    for (int k = 1; k <= 25; k++) tick();
    n_tests++;
    if (bus8.ch !== 3'd6) begin
      n_fail++;
      $display("FAIL midrst pre: ch=%0d, want 6", bus8.ch);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus8.dout !== 1'b0 || bus8.ch !== 3'd0 || bus8.valid !== 1'b0 || bus8.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: dout=%b ch=%0d valid=%b wrap=%b, want 0/0/0/0",
               bus8.dout, bus8.ch, bus8.valid, bus8.wrap);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (bus8.ch !== 3'(k / 4) || bus8.wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst resume k=%0d: ch=%0d wrap=%b, want %0d/0",
                 k, bus8.ch, bus8.wrap, k / 4);
      end
    end
  endtask

  task automatic test_scan_ch5();
    int   exp_ch;
    logic exp_w, exp_d;
    din5 = 5'b01010;
    bus5.mode = 1'b1; bus5.hold = 1'b0;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_ch = (k / 4) % 5;
      exp_w  = (k % 20 == 0);
      exp_d  = din5[((k - 1) / 4) % 5];
      n_tests++;
      if (bus5.ch !== 3'(exp_ch) || bus5.wrap !== exp_w || bus5.dout !== exp_d || bus5.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL scan5 k=%0d: ch=%0d wrap=%b dout=%b valid=%b, want %0d/%b/%b/1",
                 k, bus5.ch, bus5.wrap, bus5.dout, bus5.valid, exp_ch, exp_w, exp_d);
      end
    end
    // Out-of-range manual select, then entry into scan from it.
    bus5.mode = 1'b0; bus5.sel = 3'd6;
    tick();
    n_tests++;
    if (bus5.ch !== 3'd6 || bus5.valid !== 1'b0 || bus5.dout !== 1'b0) begin
      n_fail++;
      $display("FAIL manual5 oor: ch=%0d valid=%b dout=%b, want 6/0/0",
               bus5.ch, bus5.valid, bus5.dout);
    end
    bus5.mode = 1'b1;
    tick();
    n_tests++;
    if (bus5.ch !== 3'd0 || bus5.valid !== 1'b0 || bus5.dout !== 1'b0 || bus5.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL scan5 oor entry: ch=%0d valid=%b dout=%b wrap=%b, want 0/0/0/0",
               bus5.ch, bus5.valid, bus5.dout, bus5.wrap);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++;
      if (bus5.ch !== ((k < 4) ? 3'd0 : 3'd1) || bus5.valid !== 1'b1 || bus5.dout !== 1'b0) begin
        n_fail++;
        $display("FAIL scan5 after oor k=%0d: ch=%0d valid=%b dout=%b, want %0d/1/0",
                 k, bus5.ch, bus5.valid, bus5.dout, (k < 4) ? 0 : 1);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_manual_sweep();
    test_scan();
    test_hold();
    test_mode_switch();
    test_reset_mid_scan();
    test_scan_ch5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
